mux_demux_router: RTL

//   Registered, parametrised successor to the 4x4-bit switch/LED mux-demux. Selects one of
//   NUM_CH input channels and writes it into one of NUM_CH output channels through a 2-stage pipeline.

---
 rtl/router_pkg.sv | 19 +
 rtl/router_scan_ctr.sv | 55 +++++
 rtl/mux_demux_router.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and defaults for the mux/demux router.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    SCAN  = 2'd2
  } router_state_t;

  localparam int unsigned DefChW    = 4;
  localparam int unsigned DefNumCh  = 4;
  localparam int unsigned DefScanDiv = 4;

  // Select width for a channel count.
  function automatic int unsigned sel_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/router_scan_ctr.sv
// Auto-scan channel stepper: holds each channel for SCAN_DIV cycles, then advances,
// wrapping from NUM_CH-1 back to 0.
module router_scan_ctr
  import router_pkg::*;
#(
  parameter int unsigned NUM_CH   = DefNumCh,
  parameter int unsigned SCAN_DIV = DefScanDiv
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       run,
  output logic [sel_w(NUM_CH)-1:0]   scan_idx
);

  localparam int unsigned SelW = sel_w(NUM_CH);
  // Keep the divider at least one bit wide so SCAN_DIV=1 still elaborates.
  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [SelW-1:0] IdxLast = SelW'(NUM_CH - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [SelW-1:0] idx_q, idx_d;

  // Next-state: clear wins over counting; divider terminal count advances the index.
  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    if (clr) begin
      div_d = '0;
      idx_d = '0;
    end else if (run) begin
      if (div_q == DivLast) begin
        div_d = '0;
        idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // Divider and index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  assign scan_idx = idx_q;

endmodule

// File: rtl/mux_demux_router.sv
// Registered NUM_CH-channel mux/demux router with auto-scan.
// Stage 1 selects source data and destination; stage 2 writes the destination channel.
// Build option ROUTER_HOLD_EN: unwritten output channels keep their last value
// (latched demux). Without it, only the channel written this cycle is non-zero.
module mux_demux_router
  import router_pkg::*;
#(
  parameter int unsigned CH_W     = DefChW,
  parameter int unsigned NUM_CH   = DefNumCh,
  parameter int unsigned SCAN_DIV = DefScanDiv
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*CH_W-1:0]     din,
  input  logic [sel_w(NUM_CH)-1:0]   mux_sel,
  input  logic [sel_w(NUM_CH)-1:0]   demux_sel,
  input  logic                       enable,
  input  logic                       scan_en,
  output logic [NUM_CH*CH_W-1:0]     dout,
  output logic [sel_w(NUM_CH)-1:0]   cur_ch,
  output logic                       upd
);

  localparam int unsigned SEL_W = sel_w(NUM_CH);

  router_state_t state_q, state_d;

  logic [SEL_W-1:0]       scan_idx;
  logic                   scan_clr;
  logic                   scan_run;

  logic [SEL_W-1:0]       src;
  logic [SEL_W-1:0]       dst;
  logic                   valid1_q, valid1_d;
  logic [CH_W-1:0]        data1_q, data1_d;
  logic [SEL_W-1:0]       dst1_q, dst1_d;

  logic [NUM_CH*CH_W-1:0] dout_q, dout_d;
  logic [SEL_W-1:0]       cur_ch_q, cur_ch_d;
  logic                   upd_q, upd_d;

  // Mode FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = scan_en ? SCAN : ROUTE;
      end
      ROUTE: begin
        if (!enable)      state_d = IDLE;
        else if (scan_en) state_d = SCAN;
      end
      SCAN: begin
        if (!enable)       state_d = IDLE;
        else if (!scan_en) state_d = ROUTE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Mode FSM register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign scan_run = (state_q == SCAN);
  // Leaving SCAN restarts the next scan from channel 0.
  assign scan_clr = (state_q == SCAN) && (state_d != SCAN);

  router_scan_ctr #(
    .NUM_CH   (NUM_CH),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr      (scan_clr),
    .run      (scan_run),
    .scan_idx (scan_idx)
  );

  // Stage 1: pick source/destination; out-of-range selects never produce a write.
  always_comb begin
    src = mux_sel;
    dst = demux_sel;
    if (state_q == SCAN) begin
      src = scan_idx;
      dst = scan_idx;
    end
    valid1_d = (state_q != IDLE) && (32'(src) < NUM_CH) && (32'(dst) < NUM_CH);
    data1_d  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (32'(src) == k) data1_d = din[k*CH_W +: CH_W];
    end
    dst1_d = dst;
  end

  // Stage 1 registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1_q <= 1'b0;
      data1_q  <= '0;
      dst1_q   <= '0;
    end else begin
      valid1_q <= valid1_d;
      data1_q  <= data1_d;
      dst1_q   <= dst1_d;
    end
  end

  // Stage 2 next-state: write the destination channel.
  always_comb begin
`ifdef ROUTER_HOLD_EN
    dout_d = dout_q;
`else
    dout_d = '0;
`endif
    cur_ch_d = cur_ch_q;
    upd_d    = valid1_q;
    if (valid1_q) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (32'(dst1_q) == k) dout_d[k*CH_W +: CH_W] = data1_q;
      end
      cur_ch_d = dst1_q;
    end
  end

  // Stage 2 registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q   <= '0;
      cur_ch_q <= '0;
      upd_q    <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      cur_ch_q <= cur_ch_d;
      upd_q    <= upd_d;
    end
  end

  assign dout   = dout_q;
  assign cur_ch = cur_ch_q;
  assign upd    = upd_q;

endmodule
